sc_fifo_stream_rd: RTL
======================

# sc_fifo_stream_rd

Read-side adapter for `sc_fifo`. It drains the FIFO's `rd_i`/`rd_data_o`/`empty_o` port and re-presents the words as a valid/ready stream, with full one-word-per-cycle throughput. A 3-entry prefetch buffer absorbs the FIFO's one-cycle read latency, so no combinational path exists from `src_ready_i` to `fifo_rd_o`. It sits between `sc_fifo` and any stream consumer, sharing the FIFO's clock and reset.

## Interface
Parameters:
- `DATA_WIDTH`, default 8: word width; must match the attached `sc_fifo`.

Ports:
- `clk_i`, input, 1: clock; shared with `sc_fifo`.
- `rst_i`, input, 1: reset, asynchronous, active-high.
- `fifo_rd_o`, output, 1: read strobe to `sc_fifo.rd_i`.
- `fifo_rd_data_i`, input, `DATA_WIDTH`: from `sc_fifo.rd_data_o`; valid the cycle after a read is sampled.
- `fifo_empty_i`, input, 1: from `sc_fifo.empty_o`.
- `src_valid_o`, output, 1: stream word available.
- `src_data_o`, output, `DATA_WIDTH`: stream word.
- `src_ready_i`, input, 1: consumer accepts the word.
- `level_o`, output, 2: words held in the prefetch buffer (0..3).

## Operation
- State:
  - 3-entry data buffer.
  - `wr_ptr` and `rd_ptr`, each 0..2, wrapping 2 -> 0 (modulo 3, not power of two).
  - `level`, 0..3.
  - `inflight` flag, 0/1: a read was issued last cycle and its data is due this cycle.
- Credit: `occ = level + inflight`.
- Read issue: `fifo_rd_o = !fifo_empty_i && (occ < 3)`. It depends only on registered state and `fifo_empty_i`; `src_ready_i` must not feed it.
- Arrival: when `inflight` is 1, write `fifo_rd_data_i` into `buf[wr_ptr]` and advance `wr_ptr`.
- Pop: `src_valid_o = (level != 0)`. `src_data_o = buf[rd_ptr]`, a mux of registers only. A pop happens when `src_valid_o && src_ready_i`; `rd_ptr` then advances.
- Next state:
  - `inflight <= fifo_rd_o`.
  - `level <= level + inflight - pop`. A simultaneous arrival and pop leaves `level` unchanged.
- Overflow cannot occur by construction (occ ≤ 3). Add an assertion: arrival with `level == 3` and no pop is an error.
- `src_data_o` holds stable while `src_valid_o && !src_ready_i`.
- Order is strictly FIFO across pointer wrap.

## Timing
- Reset values: `fifo_rd_o` = 0 (forced while `rst_i` is high), `src_valid_o` = 0, `src_data_o` = 0, `level_o` = 0. Pointers, `level` and `inflight` clear to 0; the buffer clears to 0.
- Latency: a word in a non-empty FIFO with the adapter idle:
  - cycle 0: `fifo_rd_o` = 1.
  - cycle 1: data captured.
  - cycle 2: `src_valid_o` = 1.
- Throughput: with `src_ready_i` held at 1 and the FIFO non-empty, one pop per cycle in steady state (`level` = 1, `inflight` = 1).
- Backpressure: with `src_ready_i` = 0, at most 3 reads are issued. Issue stops when `occ` reaches 3 and resumes the cycle after the first pop.
- FIFO empty: no reads issue. Already-buffered words still drain normally.
- Reset mid-operation: in-flight and buffered words are discarded. `sc_fifo` must share `rst_i`; resetting only this block loses words, which is not supported.

## Structure
- Add `sc_fifo_pkg` holding:
  - `localparam int SC_FIFO_RD_LATENCY = 1`
  - `localparam int STREAM_RD_SKID_DEPTH = 3`
- The RTL is elaborated only for latency 1. An elaboration check fails for any other value.
- Single module, no sub-modules. The modulo-3 pointer increment is a local function.

## Test plan
- Reset, then FIFO filled with 0x11, 0x22, 0x33, `src_ready_i` = 1:
  - `fifo_rd_o` rises in the first cycle after reset.
  - `src_valid_o` rises 2 cycles later.
  - Words appear 0x11, 0x22, 0x33 on consecutive cycles.
- 10 words 0x00..0x09 loaded, `src_ready_i` = 0 for 20 cycles:
  - exactly 3 `fifo_rd_o` pulses; `level_o` = 3; `src_data_o` holds 0x00.
  - Release ready: 0x00..0x09 emerge in order, with no gap after the first.
- Wrap: 7 words 0x40..0x46 with `src_ready_i` toggling every cycle:
  - output order 0x40..0x46.
  - Pointers pass 2 -> 0 at least twice.
- FIFO empty mid-stream: after 2 words with ready = 1:
  - `fifo_rd_o` stays 0; `src_valid_o` drops after draining; `level_o` = 0.
- Async reset asserted mid-clock with `level_o` = 2 and `inflight` = 1:
  - all outputs 0 immediately.
  - After reset, a fresh word 0x5A is the first word out.
- Random soak (1,000,000 cycles): 50% write on the FIFO input, 50% `src_ready_i`, against a queue scoreboard:
  - no data mismatch, no overflow assertion.
  - ≥ 0.95 words per cycle when ready = 1 and the FIFO is non-empty.

Source files
------------

// File: rtl/sc_fifo_pkg.sv
// -----------------------------------------------------------------------------
// sc_fifo_pkg
// Shared constants for sc_fifo and its stream adapters.
//   SC_FIFO_RD_LATENCY   : cycles from a sampled rd_i to valid rd_data_o.
//   STREAM_RD_SKID_DEPTH : entries in the read-side prefetch buffer; this is
//                          the number of reads that may be outstanding while
//                          the stream consumer stalls.
// -----------------------------------------------------------------------------
package sc_fifo_pkg;

    localparam int SC_FIFO_RD_LATENCY   = 1;
    localparam int STREAM_RD_SKID_DEPTH = 3;

endpackage

// File: rtl/sc_fifo_stream_rd.sv
// -----------------------------------------------------------------------------
// sc_fifo_stream_rd
// Read-side adapter for sc_fifo. Drains the FIFO's rd/rd_data/empty port and
// re-presents the words as a valid/ready stream at one word per cycle. A
// 3-entry prefetch buffer covers the FIFO's one-cycle read latency, so the
// read strobe depends only on registered state and fifo_empty_i, never on
// src_ready_i.
//
// Ports:
//   clk_i          : clock, shared with sc_fifo
//   rst_i          : asynchronous active-high reset, shared with sc_fifo
//   fifo_rd_o      : read strobe to sc_fifo.rd_i
//   fifo_rd_data_i : sc_fifo.rd_data_o, valid the cycle after a read
//   fifo_empty_i   : sc_fifo.empty_o
//   src_valid_o    : stream word available
//   src_data_o     : stream word (register mux only)
//   src_ready_i    : consumer accepts the word
//   level_o        : words held in the prefetch buffer (0..3)
// -----------------------------------------------------------------------------
module sc_fifo_stream_rd
    import sc_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    output logic                  fifo_rd_o,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data_i,
    input  logic                  fifo_empty_i,
    output logic                  src_valid_o,
    output logic [DATA_WIDTH-1:0] src_data_o,
    input  logic                  src_ready_i,
    output logic [1:0]            level_o
);

    localparam int DEPTH = STREAM_RD_SKID_DEPTH;

    // The credit scheme below assumes exactly one cycle of read latency and a
    // 3-deep buffer with 2-bit modulo-3 pointers.
    if (SC_FIFO_RD_LATENCY != 1) begin : g_latency_check
        $error("sc_fifo_stream_rd: only SC_FIFO_RD_LATENCY == 1 is supported");
    end
    if (STREAM_RD_SKID_DEPTH != 3) begin : g_depth_check
        $error("sc_fifo_stream_rd: only STREAM_RD_SKID_DEPTH == 3 is supported");
    end

    logic [DATA_WIDTH-1:0] buf_reg [0:DEPTH-1];
    logic [1:0]            wr_ptr_reg;
    logic [1:0]            wr_ptr_next;
    logic [1:0]            rd_ptr_reg;
    logic [1:0]            rd_ptr_next;
    logic [1:0]            level_reg;
    logic [1:0]            level_next;
    logic                  inflight_reg;
    logic [2:0]            occ;
    logic                  pop;
    logic [DEPTH-1:0]      wr_en;

    // Pointers wrap 2 -> 0.
    function automatic logic [1:0] ptr_inc(input logic [1:0] ptr);
        return (ptr == 2'd2) ? 2'd0 : ptr + 2'd1;
    endfunction

    // Credit: buffered words plus the word still on its way from the FIFO.
    assign occ         = {1'b0, level_reg} + {2'b00, inflight_reg};
    assign fifo_rd_o   = !rst_i && !fifo_empty_i && (occ < 3'd3);
    assign src_valid_o = (level_reg != 2'd0);
    assign pop         = src_valid_o && src_ready_i;
    assign level_o     = level_reg;

    // One-hot write enable: the returning word lands at wr_ptr.
    genvar gi;
    for (gi = 0; gi < DEPTH; gi++) begin : g_wr_en
        assign wr_en[gi] = inflight_reg && (wr_ptr_reg == 2'(gi));
    end

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        level_next  = level_reg;
        if (inflight_reg) begin
            wr_ptr_next = ptr_inc(wr_ptr_reg);
        end
        if (pop) begin
            rd_ptr_next = ptr_inc(rd_ptr_reg);
        end
        // Arrival and pop in the same cycle cancel out.
        case ({inflight_reg, pop})
            2'b10:   level_next = level_reg + 2'd1;
            2'b01:   level_next = level_reg - 2'd1;
            default: level_next = level_reg;
        endcase
    end

    // Output word straight from the buffer registers.
    always_comb begin
        src_data_o = buf_reg[2];
        case (rd_ptr_reg)
            2'd0:    src_data_o = buf_reg[0];
            2'd1:    src_data_o = buf_reg[1];
            default: src_data_o = buf_reg[2];
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                buf_reg[i] <= '0;
            end
            wr_ptr_reg   <= 2'd0;
            rd_ptr_reg   <= 2'd0;
            level_reg    <= 2'd0;
            inflight_reg <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_en[i]) begin
                    buf_reg[i] <= fifo_rd_data_i;
                end
            end
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            level_reg    <= level_next;
            inflight_reg <= fifo_rd_o;
            // A word arriving into a full buffer with no pop would be lost.
            assert (!(inflight_reg && (level_reg == 2'd3) && !pop))
                else $error("sc_fifo_stream_rd: prefetch buffer overflow");
        end
    end

endmodule
